// File: rtl/dlyc_meas_pkg.sv
// Shared definitions for the delay-chain measurement controller:
// default parameter values and the FSM state encoding.
package dlyc_meas_pkg;

   // Default width of the per-run cycle counter and of the result.
   localparam int unsigned CNT_W_DEF     = 8;
   // Default log2 of the number of launches averaged per measurement.
   localparam int unsigned NAVG_LOG2_DEF = 2;
   // Default cycle count at which a run is aborted.
   localparam int unsigned TMO_DEF       = 200;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // waiting for a start request
      ST_RISE = 3'd1,   // launch high, waiting for the chain output to rise
      ST_FALL = 3'd2,   // launch low, waiting for the chain output to settle low
      ST_ACC  = 3'd3,   // fold the finished run into the accumulator
      ST_FIN  = 3'd4    // publish the averaged result
   } meas_state_e;

endpackage

// File: rtl/dlyc_sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Generic library cell; the output is only safe to use after the second flop.
module dlyc_sync2 (
   input  logic clk_i,
   input  logic rn_i,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   // Two-stage resynchronisation of d_i into the clk_i domain.
   always_ff @(posedge clk_i or negedge rn_i) begin
      if (!rn_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/dlyc_meas_ctrl.sv
// Delay-chain measurement controller. Launches an edge into a delay chain,
// counts clock cycles until the (synchronised) chain output follows, repeats
// for 2^NAVG_LOG2 runs and reports the truncated average. A run that takes
// TMO cycles in either direction aborts the whole measurement with an
// all-ones result and a sticky error flag.
module dlyc_meas_ctrl
   import dlyc_meas_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned NAVG_LOG2 = NAVG_LOG2_DEF,
   parameter int unsigned TMO       = TMO_DEF
) (
   input  logic             clk_i,
   input  logic             rn_i,
   input  logic             start_i,
   output logic             launch_o,
   input  logic             capt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             tmo_err_o,
   output logic [CNT_W-1:0] result_o
);

   // Accumulator is wide enough to sum 2^NAVG_LOG2 full-scale run values.
   localparam int unsigned ACC_W = CNT_W + NAVG_LOG2;
   // Run index keeps at least one bit so a single-run configuration still builds.
   localparam int unsigned RUN_W = (NAVG_LOG2 > 0) ? NAVG_LOG2 : 1;

   localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TMO);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'((1 << NAVG_LOG2) - 1);

   meas_state_e      state_q,   state_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [RUN_W-1:0] run_q,     run_d;
   logic [ACC_W-1:0] acc_q,     acc_d;
   logic             launch_q,  launch_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic             tmo_err_q, tmo_err_d;
   logic [CNT_W-1:0] result_q,  result_d;

   logic             capt_s2;
   logic [CNT_W-1:0] cnt_inc;
   logic             abort;

   // The chain output is asynchronous; only the second flop feeds the FSM.
   dlyc_sync2 u_capt_sync (
      .clk_i (clk_i),
      .rn_i  (rn_i),
      .d_i   (capt_i),
      .q_o   (capt_s2)
   );

   // Next-state and datapath decisions for the measurement sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      acc_d     = acc_q;
      launch_d  = launch_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tmo_err_d = tmo_err_q;
      result_d  = result_q;
      abort     = 1'b0;
      cnt_inc   = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE: begin
            // A start arriving while DONE is still high belongs to the
            // measurement that just ended and is dropped.
            if (start_i && !done_q) begin
               state_d   = ST_RISE;
               launch_d  = 1'b1;
               cnt_d     = '0;
               run_d     = '0;
               acc_d     = '0;
               busy_d    = 1'b1;
               tmo_err_d = 1'b0;
            end
         end

         ST_RISE: begin
            // cnt_q already counts every edge since launch up to the edge
            // that made s2 high, so it is the run value as it stands.
            if (capt_s2) begin
               state_d = ST_ACC;
            end else if (cnt_inc == TMO_C) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_ACC: begin
            acc_d    = acc_q + ACC_W'(cnt_q);
            launch_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_FALL;
         end

         ST_FALL: begin
            // The chain must return low before the next launch, otherwise
            // the following rise could not be detected.
            if (!capt_s2) begin
               if (run_q == RUN_LAST) begin
                  state_d = ST_FIN;
               end else begin
                  run_d    = run_q + RUN_W'(1);
                  launch_d = 1'b1;
                  cnt_d    = '0;
                  state_d  = ST_RISE;
               end
            end else if (cnt_inc == TMO_C) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_FIN: begin
            result_d = CNT_W'(acc_q >> NAVG_LOG2);
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A stalled run discards any partial average.
      if (abort) begin
         cnt_d     = cnt_inc;
         tmo_err_d = 1'b1;
         result_d  = '1;
         launch_d  = 1'b0;
         done_d    = 1'b1;
         busy_d    = 1'b0;
         state_d   = ST_IDLE;
      end
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk_i or negedge rn_i) begin
      if (!rn_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         run_q     <= '0;
         acc_q     <= '0;
         launch_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tmo_err_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         run_q     <= run_d;
         acc_q     <= acc_d;
         launch_q  <= launch_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         tmo_err_q <= tmo_err_d;
         result_q  <= result_d;
      end
   end

   assign launch_o  = launch_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign tmo_err_o = tmo_err_q;
   assign result_o  = result_q;

endmodule

// File: tb/tb_dlyc_meas_ctrl.sv
// Bench for dlyc_meas_ctrl: a behavioural delay chain echoes LAUNCH onto
// CAPT after a per-run delay of (k + 0.5) clock periods; the reference run
// value for such a delay is k + 2 cycles, and the reported result is the sum
// of the run values shifted right by NAVG_LOG2.
module tb_dlyc_meas_ctrl;

   localparam int CNT_W     = 8;
   localparam int NAVG_LOG2 = 2;
   localparam int TMO       = 200;
   localparam int NRUN      = 1 << NAVG_LOG2;
   localparam int PER       = 10;
   localparam int MAXL      = 1024;

   logic             clk_i = 1'b0;
   logic             rn_i;
   logic             start_i;
   logic             capt_i;
   logic             launch_o;
   logic             busy_o;
   logic             done_o;
   logic             tmo_err_o;
   logic [CNT_W-1:0] result_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_prev = 0;

   // chain model state
   int   rise_dly [MAXL];
   int   fall_dly [MAXL];
   int   launch_cnt = 0;
   int   done_cnt   = 0;
   logic capt_chain = 1'b0;
   logic tie0       = 1'b0;
   logic stuck_mode = 1'b0;
   logic stuck_seen = 1'b0;

   always #(PER/2) clk_i = ~clk_i;

   dlyc_meas_ctrl #(
      .CNT_W     (CNT_W),
      .NAVG_LOG2 (NAVG_LOG2),
      .TMO       (TMO)
   ) dut (
      .clk_i     (clk_i),
      .rn_i      (rn_i),
      .start_i   (start_i),
      .launch_o  (launch_o),
      .capt_i    (capt_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .tmo_err_o (tmo_err_o),
      .result_o  (result_o)
   );

   assign capt_i = tie0 ? 1'b0 : ((stuck_mode && stuck_seen) ? 1'b1 : capt_chain);

   // transport-delay chain: each launch edge reappears on capt_chain later
   always @(launch_o) begin
      automatic int   d = 0;
      automatic logic v = launch_o;
      if (v === 1'b1) begin
         d = rise_dly[launch_cnt % MAXL] * PER + PER/2;
         launch_cnt++;
      end else begin
         d = fall_dly[(launch_cnt + MAXL - 1) % MAXL] * PER + PER/2;
      end
      if (v === 1'b1 || v === 1'b0) begin
         fork
            begin
               #(d);
               capt_chain = v;
            end
         join_none
      end
   end

   always @(posedge capt_chain or negedge stuck_mode) stuck_seen = stuck_mode;

   always @(posedge clk_i) if (done_o === 1'b1) done_cnt++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_done(input bit spam, output int cycles, output bit seen);
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk_i);
         #1;
         cycles++;
         if (done_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         start_i = spam ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
      start_i = 1'b0;
   endtask

   // one measurement: start, wait for DONE, compare against the reference
   task automatic run_meas(input string tag, input int exp_res, input bit exp_tmo,
                           input int exp_runs, input int exp_cyc,
                           input bit spam, input bit coincide);
      int base;
      int cyc;
      bit seen;
      base = launch_cnt;
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check_eq({tag, ".busy_start"}, busy_o, 1);
      check_eq({tag, ".launch_start"}, launch_o, 1);
      check_eq({tag, ".tmo_clr"}, tmo_err_o, 0);
      check_eq({tag, ".result_hold"}, result_o, exp_prev);
      wait_done(spam, cyc, seen);
      check_eq({tag, ".done_seen"}, seen, 1);
      check_eq({tag, ".result"}, result_o, exp_res);
      check_eq({tag, ".tmo_err"}, tmo_err_o, exp_tmo);
      check_eq({tag, ".busy_end"}, busy_o, 0);
      check_eq({tag, ".launch_end"}, launch_o, 0);
      check_eq({tag, ".runs"}, launch_cnt - base, exp_runs);
      if (exp_cyc >= 0) check_eq({tag, ".latency"}, cyc, exp_cyc);
      $display("meas %s: result=%0d exp=%0d tmo_err=%0d runs=%0d cycles=%0d",
               tag, result_o, exp_res, tmo_err_o, launch_cnt - base, cyc);
      exp_prev = exp_res;
      if (coincide) start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check_eq({tag, ".done_width"}, done_o, 0);
      check_eq({tag, ".idle_after"}, busy_o, 0);
      check_eq({tag, ".result_kept"}, result_o, exp_res);
      if (coincide) check_eq({tag, ".coincide_ignored"}, launch_cnt - base, exp_runs);
   endtask

   // program delays for the next NRUN launches; returns the reference result
   function automatic int set_runs(input int r0, input int r1, input int r2, input int r3,
                                   input int f);
      int r [4];
      int sum;
      r = '{r0, r1, r2, r3};
      sum = 0;
      for (int i = 0; i < NRUN; i++) begin
         rise_dly[(launch_cnt + i) % MAXL] = r[i];
         fall_dly[(launch_cnt + i) % MAXL] = f;
         sum += r[i] + 2;
      end
      return sum >> NAVG_LOG2;
   endfunction

   initial begin
      int exp_res;
      int base;
      int dc;
      int rk [4];
      int fk;
      rn_i    = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < MAXL; i++) begin
         rise_dly[i] = 3;
         fall_dly[i] = 3;
      end

      // reset state
      #1;
      check_eq("rst.launch", launch_o, 0);
      check_eq("rst.busy", busy_o, 0);
      check_eq("rst.done", done_o, 0);
      check_eq("rst.tmo_err", tmo_err_o, 0);
      check_eq("rst.result", result_o, 0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rn_i = 1'b1;
      repeat (2) @(posedge clk_i);

      // constant 3.5-period chain -> runs of 5; START held into the DONE cycle
      exp_res = set_runs(3, 3, 3, 3, 3);
      run_meas("const35", exp_res, 1'b0, NRUN, -1, 1'b0, 1'b1);
      check_eq("const35.value", exp_res, 5);

      // 2.5/3.5/4.5/5.5 chain, started the cycle right after DONE
      exp_res = set_runs(2, 3, 4, 5, 2);
      run_meas("ramp", exp_res, 1'b0, NRUN, -1, 1'b0, 1'b0);

      // CAPT tied low -> abort in the first RISE at cnt = TMO
      tie0 = 1'b1;
      exp_res = set_runs(3, 3, 3, 3, 1);
      run_meas("tmo_rise", 255, 1'b1, 1, TMO, 1'b1, 1'b0);
      repeat (20) @(posedge clk_i);
      tie0 = 1'b0;
      exp_res = set_runs(4, 4, 4, 4, 1);
      run_meas("after_tmo_rise", exp_res, 1'b0, NRUN, -1, 1'b0, 1'b0);

      // CAPT stuck high after the first rise -> abort in FALL
      stuck_mode = 1'b1;
      exp_res = set_runs(3, 3, 3, 3, 1);
      run_meas("tmo_fall", 255, 1'b1, 1, -1, 1'b0, 1'b0);
      stuck_mode = 1'b0;
      repeat (20) @(posedge clk_i);

      // reset during the third RISE: immediate clear, no DONE
      exp_res = set_runs(6, 6, 6, 6, 6);
      base = launch_cnt;
      dc   = done_cnt;
      @(negedge clk_i);
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      for (int i = 0; i < 1000 && (launch_cnt - base) < 3; i++) @(posedge clk_i);
      check_eq("rstmid.third_launch", launch_cnt - base, 3);
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("rstmid.busy_before", busy_o, 1);
      #2;
      rn_i = 1'b0;
      #1;
      check_eq("rstmid.launch", launch_o, 0);
      check_eq("rstmid.busy", busy_o, 0);
      check_eq("rstmid.done", done_o, 0);
      check_eq("rstmid.tmo_err", tmo_err_o, 0);
      check_eq("rstmid.result", result_o, 0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rn_i = 1'b1;
      repeat (20) @(posedge clk_i);
      #1;
      check_eq("rstmid.no_done", done_cnt - dc, 0);
      check_eq("rstmid.idle", busy_o, 0);
      $display("meas rstmid: reset during run 3, done pulses=%0d", done_cnt - dc);
      exp_prev = 0;
      exp_res = set_runs(1, 5, 9, 2, 4);
      run_meas("after_rst", exp_res, 1'b0, NRUN, -1, 1'b0, 1'b0);

      // randomized chain delays, with spurious STARTs on odd iterations
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 4; i++) rk[i] = $urandom_range(0, 12);
         fk = $urandom_range(0, 12);
         exp_res = set_runs(rk[0], rk[1], rk[2], rk[3], fk);
         run_meas($sformatf("rand%0d", t), exp_res, 1'b0, NRUN, -1, t[0], 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #(400000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
